// File: rtl/fetch_stage.sv
// Instruction-fetch front end of the 5-stage RV32I pipeline: owns the PC,
// drives the instruction-memory address and loads the IF/ID pipeline register.
module fetch_stage #(
    parameter int unsigned                 ADDRESS_WIDTH = 32,
    parameter int unsigned                 DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = 32'h0000_0000,
    parameter int unsigned                 IMEM_BYTES    = 4096,
    parameter logic [DATA_WIDTH-1:0]       NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    input  logic                     pcsrc_e,
    input  logic [ADDRESS_WIDTH-1:0] pctarget_e,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_instr,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pcplus4_d,
    output logic                     valid_d,
    output logic                     fetch_err
);

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP        = ADDRESS_WIDTH'(32'd4);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_WORD_ADDR = ADDRESS_WIDTH'(IMEM_BYTES - 32'd4);
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR      = '0;

    // A fetch is legal only if the whole word lies inside the memory.
    function automatic logic addr_in_range(input logic [ADDRESS_WIDTH-1:0] addr);
        return (addr <= LAST_WORD_ADDR);
    endfunction

    logic [ADDRESS_WIDTH-1:0] pc_r;
    logic [ADDRESS_WIDTH-1:0] next_pc_s;
    logic [ADDRESS_WIDTH-1:0] pcplus4_f_s;
    logic [ADDRESS_WIDTH-1:0] redirect_pc_s;
    logic                     pc_in_range_s;
    logic                     ifid_load_s;
    logic                     redirect_misaligned_s;
    logic                     err_event_s;

    assign imem_addr = pc_r;

    // Next-PC selection: a resolved redirect beats a fetch stall.
    always_comb begin
        pcplus4_f_s   = pc_r + PC_STEP;
        redirect_pc_s = {pctarget_e[ADDRESS_WIDTH-1:2], 2'b00};
        next_pc_s     = pc_r;
        if (pcsrc_e) begin
            next_pc_s = redirect_pc_s;
        end else if (stall_f) begin
            next_pc_s = pc_r;
        end else begin
            next_pc_s = pcplus4_f_s;
        end
    end

    // Qualifiers for the IF/ID load and the sticky error flag.
    always_comb begin
        pc_in_range_s         = addr_in_range(pc_r);
        redirect_misaligned_s = pcsrc_e && (pctarget_e[1:0] != 2'b00);
        ifid_load_s           = 1'b0;
        if (flush_d) begin
            ifid_load_s = 1'b0;
        end else if (stall_d) begin
            ifid_load_s = 1'b0;
        end else begin
            ifid_load_s = 1'b1;
        end
        err_event_s = redirect_misaligned_s || (ifid_load_s && !pc_in_range_s);
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // IF/ID pipeline register: flush injects a bubble, stall holds, else load.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_d   <= NOP_INSTR;
            pc_d      <= ZERO_ADDR;
            pcplus4_d <= ZERO_ADDR;
            valid_d   <= 1'b0;
        end else if (flush_d) begin
            instr_d   <= NOP_INSTR;
            pc_d      <= ZERO_ADDR;
            pcplus4_d <= ZERO_ADDR;
            valid_d   <= 1'b0;
        end else if (stall_d) begin
            instr_d   <= instr_d;
            pc_d      <= pc_d;
            pcplus4_d <= pcplus4_d;
            valid_d   <= valid_d;
        end else begin
            // Out-of-range fetches still record their PC so the fault is traceable.
            instr_d   <= pc_in_range_s ? imem_instr : NOP_INSTR;
            pc_d      <= pc_r;
            pcplus4_d <= pcplus4_f_s;
            valid_d   <= pc_in_range_s;
        end
    end

    // Sticky fetch error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (err_event_s) begin
            fetch_err <= 1'b1;
        end else begin
            fetch_err <= fetch_err;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random
// stimulus, checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] CONST_WORD = 32'h0050_0093;
    localparam longint unsigned MEM_BYTES = 64'd4096;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        fetch_err;
    logic        const_mode;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pcsrc_e    (pcsrc_e),
        .pctarget_e (pctarget_e),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word, or a per-address pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic cmode);
        if (cmode) return CONST_WORD;
        return (addr * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    assign imem_instr = mem_word(imem_addr, const_mode);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: what the fetch stage should hold after each edge.
    longint unsigned m_pc;
    logic [31:0]     m_instr, m_pcd, m_p4;
    logic            m_valid, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue the expected outcome.
    task automatic step(input bit r, input bit sf, input bit sd, input bit fl,
                        input bit ps, input logic [31:0] tgt);
        exp_t e;
        longint unsigned cur;
        rst = r; stall_f = sf; stall_d = sd; flush_d = fl; pcsrc_e = ps; pctarget_e = tgt;
        if (r) begin
            m_pc = 0; m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            cur = m_pc;
            if (fl) begin
                m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 1'b0;
            end else if (!sd) begin
                m_pcd = cur[31:0];
                m_p4  = 32'((cur + 64'd4) % 64'h1_0000_0000);
                if (cur + 64'd4 <= MEM_BYTES) begin
                    m_valid = 1'b1;
                    m_instr = mem_word(cur[31:0], const_mode);
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                    m_err   = 1'b1;
                end
            end
            if (ps && (tgt % 32'd4 != 32'd0)) m_err = 1'b1;
            if (ps)       m_pc = longint'(tgt) - longint'(tgt % 32'd4);
            else if (!sf) m_pc = (cur + 64'd4) % 64'h1_0000_0000;
        end
        e.addr = m_pc[31:0]; e.instr = m_instr; e.pcd = m_pcd; e.p4 = m_p4;
        e.valid = m_valid; e.err = m_err;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: compares every registered output just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("instr_d",   instr_d,   e.instr);
                chk("pc_d",      pc_d,      e.pcd);
                chk("pcplus4_d", pcplus4_d, e.p4);
                chk("valid_d",   {31'd0, valid_d},   {31'd0, e.valid});
                chk("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic [31:0] tgt;
        int          sel;
        int          waited;
        const_mode = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run(2);                                         // pc_f reaches 8
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        run(2);                                         // pc_f reaches 16
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
        run(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0042);
        run(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0FFC);
        run(3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        run(3);                                         // PC wraps to 0
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
        run(3);

        const_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       tgt = $urandom_range(0, 1023) * 4;
                1:       tgt = 32'h0000_0FF0 + $urandom_range(0, 24);
                2:       tgt = $urandom;
                default: tgt = $urandom_range(0, 63);
            endcase
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 tgt);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage RV32I pipeline.
- Owns the program counter and drives the fetch address to the combinational, byte-addressed, little-endian instruction memory (2^12 bytes).
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles hazard-unit stalls, branch/jump redirects from Execute, and IF/ID flushes.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 4096, size of instruction memory in bytes; used for range checking.
- NOP_INSTR, 32'h0000_0013, instruction injected on flush (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall_f  input  1  hold PC (hazard unit).
- stall_d  input  1  hold IF/ID register (hazard unit).
- flush_d  input  1  replace IF/ID contents with a bubble.
- pcsrc_e  input  1  redirect taken (branch/jal/jalr resolved in Execute).
- pctarget_e  input  ADDRESS_WIDTH  redirect target.
- imem_addr  output  ADDRESS_WIDTH  fetch address to instruction memory (= pc_f).
- imem_instr  input  DATA_WIDTH  word returned combinationally by instruction memory.
- instr_d  output  DATA_WIDTH  IF/ID instruction.
- pc_d  output  ADDRESS_WIDTH  IF/ID PC.
- pcplus4_d  output  ADDRESS_WIDTH  IF/ID PC+4.
- valid_d  output  1  IF/ID holds a real fetched instruction (0 = bubble).
- fetch_err  output  1  sticky: misaligned target or PC outside memory seen.

Behaviour:
- Reset (rst=1 at clk edge):
  - pc_f=RESET_PC.
  - instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0, fetch_err=0.
  - Reset overrides every other input.
- imem_addr = pc_f, combinational. The instruction for pc_f is visible on instr_d one cycle later, so fetch-to-decode latency is 1 clock.
- PC next-state priority, highest first:
  1. pcsrc_e=1: pc_f <= {pctarget_e[31:2],2'b00}. Taken even if stall_f=1.
  2. stall_f=1: pc_f holds.
  3. Otherwise: pc_f <= pc_f + 4, modulo 2^ADDRESS_WIDTH (0xFFFF_FFFC wraps to 0).
- IF/ID register priority, highest first:
  1. flush_d=1: instr_d=NOP_INSTR, valid_d=0, pc_d and pcplus4_d = 0. Flush wins over stall_d.
  2. stall_d=1: all IF/ID outputs hold.
  3. Otherwise:
     - instr_d=imem_instr, pc_d=pc_f, pcplus4_d=pc_f+4.
     - valid_d=1 if pc_f is in range, else 0 with instr_d=NOP_INSTR.
- Range check: pc_f is in range iff pc_f <= IMEM_BYTES-4.
- fetch_err:
  - Set when pcsrc_e=1 and pctarget_e[1:0]!=0.
  - Set when an IF/ID load (case 3 above) occurs with pc_f out of range.
  - Cleared only by rst.
- Simultaneous pcsrc_e=1 and flush_d=1, the normal taken-branch case: PC takes the target and IF/ID becomes a bubble in the same edge.
- stall_f=1 with stall_d=0 is legal: the same PC is re-latched into IF/ID. This is not a hazard-unit error.
- All outputs are registered except imem_addr.

Test Plan:
- Reset then 4 free-running cycles, imem returning 32'h00500093 for every address -> imem_addr sequence 0,4,8,12; pc_d 0,4,8 with valid_d=1, pcplus4_d=pc_d+4; outputs before the first load are NOP/0/0.
- At pc_f=8, assert stall_f=1 and stall_d=1 for 2 cycles -> imem_addr stays 8; instr_d/pc_d hold at pc_d=4; after release, the sequence resumes with pc_d=8.
- At pc_f=16, pulse pcsrc_e=1, flush_d=1, pctarget_e=32'h40 -> next cycle imem_addr=0x40, valid_d=0, instr_d=0x00000013; following cycle pc_d=0x40 with valid_d=1.
- pcsrc_e=1, pctarget_e=32'h42, together with stall_f=1 -> pc_f=0x40 (redirect beats stall, low bits cleared); fetch_err=1 and stays 1 until rst.
- Redirect to 0xFFC, run 2 cycles -> pc_d=0xFFC valid_d=1, then pc_f=0x1000 loads valid_d=0, instr_d=NOP, fetch_err=1.
- Assert rst mid-stream while pcsrc_e=1 and stall_f=1 -> next cycle pc_f=RESET_PC, valid_d=0, fetch_err=0.
